// File: rtl/bram_arb_pkg.sv
// Shared geometry and issue-stage record for the dual-port BRAM arbiter.
package bram_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 6;
   localparam int DEF_DATA_W  = 128;
   localparam int DEF_ID_W    = 2;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_ID_W-1:0]   id;
   } issue_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-winner round-robin picker; the second winner skips requesters
// whose address collides with the first when either side writes.
module rr_pick2
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic [NUM_REQ-1:0]        valid,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [ID_W-1:0]           ptr,
   output logic                      grant_a,
   output logic [ID_W-1:0]           idx_a,
   output logic                      grant_b,
   output logic [ID_W-1:0]           idx_b,
   output logic [NUM_REQ-1:0]        ready
);

   int                pos;
   logic [ADDR_W-1:0] a_addr;
   logic              a_we;
   logic              clash;

   always_comb begin
      grant_a = 1'b0;
      idx_a   = '0;
      grant_b = 1'b0;
      idx_b   = '0;
      ready   = '0;
      pos     = 0;
      a_addr  = '0;
      a_we    = 1'b0;
      clash   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ)
            pos = pos - NUM_REQ;
         clash = (addr[pos*ADDR_W +: ADDR_W] == a_addr)
               && (a_we || we[pos]);
         if (valid[pos]) begin
            if (!grant_a) begin
               grant_a    = 1'b1;
               idx_a      = ID_W'(pos);
               a_addr     = addr[pos*ADDR_W +: ADDR_W];
               a_we       = we[pos];
               ready[pos] = 1'b1;
            end else if (!grant_b && !clash) begin
               grant_b    = 1'b1;
               idx_b      = ID_W'(pos);
               ready[pos] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bram_dp_arbiter.sv
// Round-robin sharing of one true-dual-port BRAM between NUM_REQ clients,
// with registered issue into the RAM and id-tagged read responses.
module bram_dp_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic                      mem_ena,
   output logic                      mem_enb,
   output logic                      mem_wea,
   output logic                      mem_web,
   output logic [ADDR_W-1:0]         mem_addra,
   output logic [ADDR_W-1:0]         mem_addrb,
   output logic [DATA_W-1:0]         mem_dia,
   output logic [DATA_W-1:0]         mem_dib,
   input  logic [DATA_W-1:0]         mem_doa,
   input  logic [DATA_W-1:0]         mem_dob,
   output logic                      rsp_a_valid,
   output logic                      rsp_b_valid,
   output logic [ID_W-1:0]           rsp_a_id,
   output logic [ID_W-1:0]           rsp_b_id,
   output logic [DATA_W-1:0]         rsp_a_data,
   output logic [DATA_W-1:0]         rsp_b_data
);

   logic [ID_W-1:0]    rr_ptr;
   logic               grant_a;
   logic               grant_b;
   logic [ID_W-1:0]    idx_a;
   logic [ID_W-1:0]    idx_b;
   logic [NUM_REQ-1:0] pick_ready;
   logic [ID_W-1:0]    last;
   logic [ID_W:0]      inc;
   logic [ID_W-1:0]    next_ptr;
   logic               en_a;
   logic               en_b;
   issue_t             iss_a;
   issue_t             iss_b;
   issue_t             nxt_a;
   issue_t             nxt_b;

   rr_pick2 #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .ID_W    (ID_W)
   ) u_pick (
      .valid   (req_valid),
      .we      (req_we),
      .addr    (req_addr),
      .ptr     (rr_ptr),
      .grant_a (grant_a),
      .idx_a   (idx_a),
      .grant_b (grant_b),
      .idx_b   (idx_b),
      .ready   (pick_ready)
   );

   // No handshakes while reset is held, even though inputs may be valid.
   assign req_ready = pick_ready & {NUM_REQ{~reset}};

   assign last     = grant_b ? idx_b : idx_a;
   assign inc      = {1'b0, last} + (ID_W+1)'(1);
   assign next_ptr = (inc == (ID_W+1)'(NUM_REQ)) ? '0 : inc[ID_W-1:0];

   assign nxt_a = '{
      we:    req_we[idx_a],
      addr:  req_addr[idx_a*ADDR_W +: ADDR_W],
      wdata: req_wdata[idx_a*DATA_W +: DATA_W],
      id:    idx_a
   };
   assign nxt_b = '{
      we:    req_we[idx_b],
      addr:  req_addr[idx_b*ADDR_W +: ADDR_W],
      wdata: req_wdata[idx_b*DATA_W +: DATA_W],
      id:    idx_b
   };

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr      <= '0;
         en_a        <= 1'b0;
         en_b        <= 1'b0;
         iss_a       <= '0;
         iss_b       <= '0;
         rsp_a_valid <= 1'b0;
         rsp_b_valid <= 1'b0;
         rsp_a_id    <= '0;
         rsp_b_id    <= '0;
      end else begin
         en_a <= grant_a;
         en_b <= grant_b;
         if (grant_a)
            iss_a <= nxt_a;
         if (grant_b)
            iss_b <= nxt_b;
         if (grant_a)
            rr_ptr <= next_ptr;
         rsp_a_valid <= en_a & ~iss_a.we;
         rsp_b_valid <= en_b & ~iss_b.we;
         rsp_a_id    <= iss_a.id;
         rsp_b_id    <= iss_b.id;
      end
   end

   assign mem_ena   = en_a;
   assign mem_enb   = en_b;
   assign mem_wea   = en_a & iss_a.we;
   assign mem_web   = en_b & iss_b.we;
   assign mem_addra = iss_a.addr;
   assign mem_addrb = iss_b.addr;
   assign mem_dia   = iss_a.wdata;
   assign mem_dib   = iss_b.wdata;

   assign rsp_a_data = mem_doa;
   assign rsp_b_data = mem_dob;

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// Directed and random checks of bram_dp_arbiter against a queue-based
// grant model and an array memory model, with a behavioural BRAM attached.
module tb_bram_dp_arbiter;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [3:0]   req_we;
   logic [23:0]  req_addr;
   logic [511:0] req_wdata;
   logic         mem_ena, mem_enb, mem_wea, mem_web;
   logic [5:0]   mem_addra, mem_addrb;
   logic [127:0] mem_dia, mem_dib;
   logic [127:0] mem_doa = '0;
   logic [127:0] mem_dob = '0;
   logic         rsp_a_valid, rsp_b_valid;
   logic [1:0]   rsp_a_id, rsp_b_id;
   logic [127:0] rsp_a_data, rsp_b_data;

   always #5 clock = ~clock;

   bram_dp_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .mem_ena     (mem_ena),
      .mem_enb     (mem_enb),
      .mem_wea     (mem_wea),
      .mem_web     (mem_web),
      .mem_addra   (mem_addra),
      .mem_addrb   (mem_addrb),
      .mem_dia     (mem_dia),
      .mem_dib     (mem_dib),
      .mem_doa     (mem_doa),
      .mem_dob     (mem_dob),
      .rsp_a_valid (rsp_a_valid),
      .rsp_b_valid (rsp_b_valid),
      .rsp_a_id    (rsp_a_id),
      .rsp_b_id    (rsp_b_id),
      .rsp_a_data  (rsp_a_data),
      .rsp_b_data  (rsp_b_data)
   );

   // Behavioural read-first true-dual-port RAM owned by the parent.
   logic [127:0] ram [64] = '{default: '0};

   always @(posedge clock) begin
      if (mem_ena) begin
         mem_doa <= ram[mem_addra];
         if (mem_wea)
            ram[mem_addra] <= mem_dia;
      end
      if (mem_enb) begin
         mem_dob <= ram[mem_addrb];
         if (mem_web)
            ram[mem_addrb] <= mem_dib;
      end
   end

   typedef struct {
      logic         en;
      logic         we;
      logic [5:0]   addr;
      logic [127:0] di;
      logic [1:0]   id;
      logic [127:0] rd;
   } slot_t;

   int           total = 0;
   int           bad   = 0;
   logic [3:0]   v, w;
   logic [5:0]   ad [4];
   logic [127:0] wd [4];
   logic [127:0] ref_mem [64] = '{default: '0};
   int           ref_ptr = 0;
   slot_t        s1 [2];
   slot_t        s2 [2];
   slot_t        pend [2];
   logic [3:0]   last_ready;
   logic [127:0] pat_aa = {16{8'hAA}};
   logic [127:0] pat_9  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic slot_t mk(int g);
      slot_t s;
      s.en = 1'b0; s.we = 1'b0; s.addr = '0;
      s.di = '0;   s.id = '0;   s.rd = '0;
      if (g >= 0) begin
         s.en   = 1'b1;
         s.we   = w[g];
         s.addr = ad[g];
         s.di   = wd[g];
         s.id   = 2'(g);
         s.rd   = ref_mem[ad[g]];
      end
      return s;
   endfunction

   // Spec-level arbitration: rotate the valid list from the pointer,
   // A is its head, B is the first later entry not clashing with A.
   task automatic model_pick(output int ga, output int gb);
      int q[$];
      ga = -1;
      gb = -1;
      for (int k = 0; k < 4; k++)
         if (v[(ref_ptr + k) % 4])
            q.push_back((ref_ptr + k) % 4);
      if (q.size() > 0)
         ga = q[0];
      for (int j = 1; j < q.size(); j++)
         if (gb < 0 && !(ad[q[j]] == ad[ga] && (w[q[j]] || w[ga])))
            gb = q[j];
   endtask

   task automatic chk_port(input int p, input string n,
                           input logic en, input logic we,
                           input logic [5:0] addr, input logic [127:0] di,
                           input logic rv, input logic [1:0] rid,
                           input logic [127:0] rd);
      logic ev;
      chk({n, "_en"}, en, s1[p].en);
      chk({n, "_we"}, we, s1[p].en && s1[p].we);
      if (s1[p].en)
         chk({n, "_addr"}, addr, s1[p].addr);
      if (s1[p].en && s1[p].we)
         chk({n, "_di"}, di, s1[p].di);
      ev = s2[p].en && !s2[p].we;
      chk({n, "_rsp_valid"}, rv, ev);
      if (ev) begin
         chk({n, "_rsp_id"}, rid, s2[p].id);
         chk({n, "_rsp_data"}, rd, s2[p].rd);
      end
   endtask

   task automatic cycle();
      int         ga, gb;
      logic [3:0] er;
      req_valid = v;
      req_we    = w;
      req_addr  = {ad[3], ad[2], ad[1], ad[0]};
      req_wdata = {wd[3], wd[2], wd[1], wd[0]};
      #1;
      ga = -1;
      gb = -1;
      if (!reset)
         model_pick(ga, gb);
      er = '0;
      if (ga >= 0) er[ga] = 1'b1;
      if (gb >= 0) er[gb] = 1'b1;
      last_ready = req_ready;
      chk("ready", req_ready, er);
      pend[0] = mk(ga);
      pend[1] = mk(gb);
      if (ga >= 0 && w[ga]) ref_mem[ad[ga]] = wd[ga];
      if (gb >= 0 && w[gb]) ref_mem[ad[gb]] = wd[gb];
      if (gb >= 0)
         ref_ptr = (gb + 1) % 4;
      else if (ga >= 0)
         ref_ptr = (ga + 1) % 4;
      @(posedge clock);
      #1;
      s2 = s1;
      s1 = pend;
      chk_port(0, "a", mem_ena, mem_wea, mem_addra, mem_dia,
               rsp_a_valid, rsp_a_id, rsp_a_data);
      chk_port(1, "b", mem_enb, mem_web, mem_addrb, mem_dib,
               rsp_b_valid, rsp_b_id, rsp_b_data);
   endtask

   task automatic idle();
      v = '0;
      w = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      ref_ptr = 0;
      for (int p = 0; p < 2; p++) begin
         s1[p] = mk(-1);
         s2[p] = mk(-1);
      end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         s1[p] = mk(-1);
         s2[p] = mk(-1);
      end
      for (int i = 0; i < 4; i++) begin
         ad[i] = '0;
         wd[i] = '0;
      end
      #1 reset = 1'b1;

      // reset held while every requester is valid
      v = 4'b1111;
      w = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rst_ready", last_ready, 4'b0000);
         chk("rst_ena", mem_ena, 1'b0);
         chk("rst_enb", mem_enb, 1'b0);
         chk("rst_rsp", {rsp_a_valid, rsp_b_valid}, 2'b00);
      end
      reset = 1'b0;

      // write then read-after-write from another requester
      idle();
      v = 4'b0001; w = 4'b0001; ad[0] = 6'd5; wd[0] = pat_aa;
      cycle();
      chk("raw_wr_ready", last_ready, 4'b0001);
      v = 4'b0010; w = 4'b0000; ad[1] = 6'd5;
      cycle();
      chk("raw_rd_ready", last_ready, 4'b0010);
      idle();
      cycle();
      chk("raw_valid", rsp_a_valid, 1'b1);
      chk("raw_id", rsp_a_id, 2'd1);
      chk("raw_data", rsp_a_data, pat_aa);

      pulse_reset();

      // all four reading distinct addresses from pointer 0
      v = 4'b1111; w = 4'b0000;
      ad[0] = 6'd10; ad[1] = 6'd11; ad[2] = 6'd12; ad[3] = 6'd13;
      cycle();
      chk("rr_g0", last_ready, 4'b0011);
      cycle();
      chk("rr_g1", last_ready, 4'b1100);
      cycle();
      chk("rr_g2", last_ready, 4'b0011);
      idle();
      cycle();
      cycle();

      // same-cycle write/read clash on address 9
      v = 4'b0011; w = 4'b0001;
      ad[0] = 6'd9; ad[1] = 6'd9; wd[0] = pat_9;
      cycle();
      chk("clash_g0", last_ready, 4'b0001);
      v = 4'b0010; w = 4'b0000;
      cycle();
      chk("clash_g1", last_ready, 4'b0010);
      idle();
      cycle();
      chk("clash_valid", rsp_a_valid, 1'b1);
      chk("clash_id", rsp_a_id, 2'd1);
      chk("clash_data", rsp_a_data, pat_9);

      // two reads of one address share the cycle
      v = 4'b1100; w = 4'b0000; ad[2] = 6'd12; ad[3] = 6'd12;
      cycle();
      chk("dual_ready", last_ready, 4'b1100);
      idle();
      cycle();
      chk("dual_valid", {rsp_a_valid, rsp_b_valid}, 2'b11);
      chk("dual_ids", {rsp_a_id, rsp_b_id}, {2'd2, 2'd3});
      chk("dual_same", rsp_a_data, rsp_b_data);

      // reset one cycle after a read grant drops the response
      v = 4'b0001; w = 4'b0000; ad[0] = 6'd5;
      cycle();
      chk("kill_ready", last_ready, 4'b0001);
      pulse_reset();
      idle();
      cycle();
      chk("kill_rsp0", {rsp_a_valid, rsp_b_valid}, 2'b00);
      cycle();
      chk("kill_rsp1", {rsp_a_valid, rsp_b_valid}, 2'b00);
      v = 4'b1111; w = 4'b0000;
      ad[0] = 6'd5; ad[1] = 6'd9; ad[2] = 6'd20; ad[3] = 6'd21;
      cycle();
      chk("post_rst_ready", last_ready, 4'b0011);
      idle();
      cycle();
      chk("post_rst_valid", {rsp_a_valid, rsp_b_valid}, 2'b11);
      chk("post_rst_ids", {rsp_a_id, rsp_b_id}, {2'd0, 2'd1});
      chk("post_rst_data_a", rsp_a_data, pat_aa);
      chk("post_rst_data_b", rsp_b_data, pat_9);

      // random traffic over a small address window to force clashes
      for (int n = 0; n < 400; n++) begin
         v = 4'($urandom);
         w = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0)
               ad[i] = 6'($urandom_range(0, 63));
            else
               ad[i] = 6'($urandom_range(0, 7));
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
         end
         cycle();
      end
      idle();
      cycle();
      cycle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
